// File: rtl/lpc_sniffer_pkg.sv
// rtl/lpc_sniffer_pkg.sv - shared FSM states, record byte layout and record builder
package lpc_sniffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] B_TYPE  = 3'd0;
  localparam logic [2:0] B_ADDR3 = 3'd1;
  localparam logic [2:0] B_ADDR2 = 3'd2;
  localparam logic [2:0] B_ADDR1 = 3'd3;
  localparam logic [2:0] B_ADDR0 = 3'd4;
  localparam logic [2:0] B_DATA  = 3'd5;
  localparam logic [2:0] B_SEQ   = 3'd6;
  localparam logic [2:0] B_STAMP = 3'd7;
  localparam int         OVF_BIT = 7;

  // Packs the record with byte 0 in the top byte, so the writer can shift it out MSB first.
  function automatic logic [63:0] build_record(input logic        ovf,
                                               input logic [3:0]  ctd,
                                               input logic [31:0] addr,
                                               input logic [7:0]  data,
                                               input logic [7:0]  seq,
                                               input logic [7:0]  stamp);
    logic [7:0]  b [8];
    logic [63:0] rec;
    b[B_TYPE]          = {4'h0, ctd};
    b[B_TYPE][OVF_BIT] = ovf;
    b[B_ADDR3]         = addr[31:24];
    b[B_ADDR2]         = addr[23:16];
    b[B_ADDR1]         = addr[15:8];
    b[B_ADDR0]         = addr[7:0];
    b[B_DATA]          = data;
    b[B_SEQ]           = seq;
    b[B_STAMP]         = stamp;
    rec = '0;
    for (int i = 0; i < 8; i++) begin
      rec[63-8*i -: 8] = b[i];
    end
    return rec;
  endfunction

endpackage

// File: rtl/lpc_slot_ring.sv
// rtl/lpc_slot_ring.sv - write slot pointer and filled-slot accounting
module lpc_slot_ring #(
  parameter int PTR_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance_i,
  input  logic             release_i,
  output logic [PTR_W-1:0] wr_ptr_d_o,
  output logic [PTR_W:0]   slots_used_o,
  output logic             full_o
);

  localparam logic [PTR_W:0] NUM_SLOTS = {1'b1, {PTR_W{1'b0}}};
  localparam logic [PTR_W:0] LAST_FREE = {1'b0, {PTR_W{1'b1}}};

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   used_q;
  logic [PTR_W:0]   used_d;
  logic             rel_ok;

  always_comb begin
    rel_ok = release_i && (used_q != '0);
    used_d = used_q;
    if (advance_i && !rel_ok) begin
      used_d = used_q + (PTR_W+1)'(1);
    end else if (!advance_i && rel_ok) begin
      used_d = used_q - (PTR_W+1)'(1);
    end
  end

  assign wr_ptr_d_o   = wr_ptr_q + PTR_W'(advance_i);
  assign slots_used_o = used_q;
  // The record finishing this cycle already owns its slot.
  assign full_o       = (used_q == NUM_SLOTS) || (advance_i && (used_q == LAST_FREE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d_o;
      used_q   <= used_d;
    end
  end

endmodule

// File: rtl/lpc_frame_writer.sv
// rtl/lpc_frame_writer.sv - writes each sampled LPC frame as an 8-byte record into a slot RAM
// Define LPC_FRAME_TIMESTAMP_EN to store a free-running capture stamp in byte 7.
module lpc_frame_writer
  import lpc_sniffer_pkg::*;
#(
  parameter int RAM_ADDR_W = 8,
  parameter int SEQ_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            lpc_cyctype_dir,
  input  logic [31:0]           lpc_addr,
  input  logic [7:0]            lpc_data,
  input  logic                  lpc_valid,
  input  logic                  slot_release,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_we,
  output logic                  frame_done,
  output logic [RAM_ADDR_W-3:0] slots_used,
  output logic [7:0]            drop_count
);

  localparam int PTR_W = RAM_ADDR_W - 3;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [63:0]      rec_q;
  logic [SEQ_W-1:0] seq_q;
  logic             ovf_q;
  logic             pend_vld_q;
  logic [3:0]       pend_ctd_q;
  logic [31:0]      pend_addr_q;
  logic [7:0]       pend_data_q;

  logic [PTR_W-1:0] wr_ptr_d;
  logic             full;
  logic             decide;
  logic             take_pend;
  logic             take_in;
  logic             store_pend;
  logic             start;
  logic [1:0]       ndrop;
  logic [3:0]       cand_ctd;
  logic [31:0]      cand_addr;
  logic [7:0]       cand_data;
  logic [7:0]       cand_stamp;
  logic [SEQ_W-1:0] rec_seq;
  logic [63:0]      rec_d;
  logic [8:0]       drop_sum;
  logic [7:0]       drop_d;

  lpc_slot_ring #(.PTR_W(PTR_W)) u_ring (
    .clock       (clock),
    .reset       (reset),
    .advance_i   (frame_done),
    .release_i   (slot_release),
    .wr_ptr_d_o  (wr_ptr_d),
    .slots_used_o(slots_used),
    .full_o      (full)
  );

`ifdef LPC_FRAME_TIMESTAMP_EN
  logic [7:0] stamp_q;
  logic [7:0] pend_stamp_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stamp_q      <= '0;
      pend_stamp_q <= '0;
    end else begin
      stamp_q <= stamp_q + 8'd1;
      if (store_pend) pend_stamp_q <= stamp_q;
    end
  end

  assign cand_stamp = take_pend ? pend_stamp_q : stamp_q;
`else
  assign cand_stamp = 8'h00;
`endif

  // A held frame always wins over a new strobe; the pending slot drains at every decision point.
  always_comb begin
    decide     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    take_pend  = decide && pend_vld_q;
    take_in    = decide && !pend_vld_q && lpc_valid;
    store_pend = (state_q == ST_WRITE) && lpc_valid && !pend_vld_q;
    start      = (take_pend || take_in) && !full;
    ndrop      = 2'((take_pend || take_in) && full) + 2'(lpc_valid && pend_vld_q);
    cand_ctd   = take_pend ? pend_ctd_q  : lpc_cyctype_dir;
    cand_addr  = take_pend ? pend_addr_q : lpc_addr;
    cand_data  = take_pend ? pend_data_q : lpc_data;
    rec_seq    = (state_q == ST_DONE) ? seq_q + SEQ_W'(1) : seq_q;
    rec_d      = build_record(ovf_q, cand_ctd, cand_addr, cand_data, 8'(rec_seq), cand_stamp);
    drop_sum   = {1'b0, drop_count} + {7'd0, ndrop};
    drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= B_TYPE;
      rec_q       <= '0;
      seq_q       <= '0;
      ovf_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_ctd_q  <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      drop_count  <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
      frame_done  <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      drop_count <= drop_d;
      ovf_q      <= (ovf_q && !start) || (ndrop != 2'd0);
      if (take_pend) begin
        pend_vld_q <= 1'b0;
      end else if (store_pend) begin
        pend_vld_q  <= 1'b1;
        pend_ctd_q  <= lpc_cyctype_dir;
        pend_addr_q <= lpc_addr;
        pend_data_q <= lpc_data;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          seq_q <= rec_seq;
          if (start) begin
            state_q  <= ST_WRITE;
            idx_q    <= B_TYPE;
            rec_q    <= {rec_d[55:0], 8'h00};
            ram_we   <= 1'b1;
            ram_addr <= {wr_ptr_d, B_TYPE};
            ram_data <= rec_d[63:56];
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (idx_q == B_STAMP) begin
            state_q    <= ST_DONE;
            frame_done <= 1'b1;
          end else begin
            idx_q    <= idx_q + 3'd1;
            ram_we   <= 1'b1;
            ram_addr <= {wr_ptr_d, idx_q + 3'd1};
            ram_data <= rec_q[63:56];
            rec_q    <= {rec_q[55:0], 8'h00};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_frame_writer.sv
// tb/tb_lpc_frame_writer.sv - directed and random checks of lpc_frame_writer against a frame-level model
module tb_lpc_frame_writer;

  localparam int NUM = 4;
`ifdef LPC_FRAME_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  lpc_cyctype_dir = '0;
  logic [31:0] lpc_addr = '0;
  logic [7:0]  lpc_data = '0;
  logic        lpc_valid = 1'b0;
  logic        slot_release = 1'b0;
  logic [4:0]  ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        frame_done;
  logic [2:0]  slots_used;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [32];

  int c, cur_start, cur_slot, m_used, m_ptr, m_seq, m_drop, m_stamp, exp_addr;
  bit m_ovf, pend_v;
  logic [7:0]  cur_rec [8];
  logic [7:0]  exp_data;
  logic [3:0]  p_ctd;
  logic [31:0] p_addr;
  logic [7:0]  p_data, p_stamp;

  lpc_frame_writer #(.RAM_ADDR_W(5), .SEQ_W(8)) dut (
    .clock(clock), .reset(reset), .lpc_cyctype_dir(lpc_cyctype_dir), .lpc_addr(lpc_addr),
    .lpc_data(lpc_data), .lpc_valid(lpc_valid), .slot_release(slot_release),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .frame_done(frame_done),
    .slots_used(slots_used), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (ram_we) mem[ram_addr] <= ram_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur_start = c - 100;
    cur_slot = 0; m_used = 0; m_ptr = 0; m_seq = 0; m_drop = 0; m_stamp = 0;
    m_ovf = 0; pend_v = 0; exp_addr = 0; exp_data = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1; lpc_valid = 1'b1; slot_release = 1'b1;
    #1;
    check("rst_ram_we", ram_we, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_slots_used", slots_used, 0);
    check("rst_drop_count", drop_count, 0);
    model_reset();
    @(posedge clock); @(posedge clock); @(negedge clock);
    lpc_valid = 1'b0; slot_release = 1'b0; reset = 1'b0;
  endtask

  // One clock: compare outputs with the model, apply inputs, advance the model, step to next negedge.
  task automatic cyc(input bit v, input logic [3:0] ctd, input logic [31:0] a, input logic [7:0] d, input bit rel);
    int k, ndrop;
    bit wr, done, decide, full, have, started, rel_ok;
    logic [3:0]  cc;
    logic [31:0] ca;
    logic [7:0]  cd, cs;
    k = c - cur_start;
    wr = (k >= 1) && (k <= 8);
    done = (k == 9);
    if (wr) begin
      exp_addr = cur_slot * 8 + (k - 1);
      exp_data = cur_rec[k-1];
    end
    check("ram_we", ram_we, wr);
    check("ram_addr", ram_addr, exp_addr);
    check("ram_data", ram_data, exp_data);
    check("frame_done", frame_done, done);
    check("slots_used", slots_used, m_used);
    check("drop_count", drop_count, m_drop);
    lpc_valid = v; lpc_cyctype_dir = ctd; lpc_addr = a; lpc_data = d; slot_release = rel;

    decide = (k >= 9);
    full = (m_used + int'(done)) == NUM;
    if (done) begin
      m_ptr = (m_ptr + 1) % NUM;
      m_seq = (m_seq + 1) % 256;
    end
    ndrop = 0; have = 0; started = 0;
    cc = ctd; ca = a; cd = d; cs = 8'(m_stamp);
    if (decide) begin
      if (pend_v) begin
        have = 1; cc = p_ctd; ca = p_addr; cd = p_data; cs = p_stamp; pend_v = 0;
        if (v) ndrop++;
      end else if (v) begin
        have = 1;
      end
    end else if (v) begin
      if (pend_v) ndrop++;
      else begin pend_v = 1; p_ctd = ctd; p_addr = a; p_data = d; p_stamp = 8'(m_stamp); end
    end
    if (have) begin
      if (full) ndrop++;
      else begin
        started = 1; cur_start = c; cur_slot = m_ptr;
        cur_rec[0] = {m_ovf, 3'b000, cc};
        cur_rec[1] = ca[31:24]; cur_rec[2] = ca[23:16]; cur_rec[3] = ca[15:8]; cur_rec[4] = ca[7:0];
        cur_rec[5] = cd; cur_rec[6] = 8'(m_seq);
        cur_rec[7] = TS_EN ? cs : 8'h00;
      end
    end
    m_drop = (m_drop + ndrop > 255) ? 255 : m_drop + ndrop;
    m_ovf = (m_ovf && !started) || (ndrop > 0);
    rel_ok = rel && (m_used > 0);
    if (done && !rel_ok) m_used++;
    else if (!done && rel_ok) m_used--;
    m_stamp = (m_stamp + 1) % 256;
    c++;
    @(posedge clock); @(negedge clock);
  endtask

  task automatic frame(input logic [3:0] ctd, input logic [31:0] a, input logic [7:0] d);
    cyc(1'b1, ctd, a, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] exp34 [7];
    exp34 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hA5, 8'h00};
    c = 0;
    #2;
    do_reset();

    // Single frame layout and latency.
    frame(4'h0, 32'h0000_0080, 8'hA5);
    idle(12);
    for (int i = 0; i < 7; i++) check($sformatf("single_b%0d", i), mem[i], exp34[i]);
    check("single_used", slots_used, 1);

    // Second frame pending behind the first.
    do_reset();
    frame(4'h1, 32'h1234_5678, 8'h11);
    idle(2);
    frame(4'h2, 32'hDEAD_BEEF, 8'h22);
    idle(20);
    check("pend_seq0", mem[6], 8'h00);
    check("pend_seq1", mem[14], 8'h01);
    check("pend_b0", mem[8], 8'h02);
    check("pend_data", mem[13], 8'h22);
    check("pend_used", slots_used, 2);

    // frame_done with release in the same cycle, then release at zero.
    frame(4'h3, 32'h0000_03F8, 8'h33);
    idle(8);
    cyc(1'b0, 4'h0, 32'h0, 8'h00, 1'b1);
    check("done_rel_used", slots_used, 2);
    cyc(1'b0, 4'h0, 32'h0, 8'h00, 1'b1);
    cyc(1'b0, 4'h0, 32'h0, 8'h00, 1'b1);
    cyc(1'b0, 4'h0, 32'h0, 8'h00, 1'b1);
    check("rel_at_zero", slots_used, 0);

    // Overflow with four slots, then ovf reported once.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      frame(4'(i), $urandom, 8'($urandom));
      idle(11);
    end
    check("ovf_drop1", drop_count, 1);
    check("ovf_used4", slots_used, 4);
    cyc(1'b0, 4'h0, 32'h0, 8'h00, 1'b1);
    frame(4'h6, 32'hCAFE_0001, 8'h5A);
    idle(12);
    check("ovf_bit_set", mem[0] >> 7, 1);
    cyc(1'b0, 4'h0, 32'h0, 8'h00, 1'b1);
    frame(4'h7, 32'hCAFE_0002, 8'h5B);
    idle(12);
    check("ovf_bit_clear", mem[8] >> 7, 0);

    // Saturating drop counter.
    for (int i = 0; i < 300; i++) cyc(1'b1, 4'h4, $urandom, 8'($urandom), 1'b0);
    check("drop_sat", drop_count, 8'hFF);
    idle(2);

    // Reset in the middle of a record.
    do_reset();
    frame(4'h1, 32'h0000_0010, 8'h01);
    idle(12);
    frame(4'h1, 32'h0000_0020, 8'h02);
    idle(12);
    for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
    frame(4'h1, 32'h0000_0030, 8'h03);
    idle(4);
    check("mid_we", ram_we, 1);
    check("mid_idx", ram_addr, 8 * 2 + 4);
    do_reset();
    frame(4'h9, 32'h0000_0040, 8'h77);
    idle(12);
    check("post_rst_b0", mem[0], 8'h09);
    check("post_rst_data", mem[5], 8'h77);
    check("post_rst_seq", mem[6], 8'h00);
    check("post_rst_used", slots_used, 1);

`ifdef LPC_FRAME_TIMESTAMP_EN
    do_reset();
    frame(4'h2, 32'h0000_0060, 8'h10);
    idle(9);
    frame(4'h2, 32'h0000_0061, 8'h11);
    idle(12);
    check("stamp_delta", 8'(mem[15] - mem[7]), 8'h0A);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 99) < 35, 4'($urandom), $urandom, 8'($urandom), $urandom_range(0, 99) < 15);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
